// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the packed-BCD arithmetic blocks.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam int BCD_CORR    = 6;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit combinational BCD adder with carry and invalid-digit flag.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a_d,
    input  logic [BCD_DIGIT_W-1:0] b_d,
    input  logic                   ci,
    output logic [BCD_DIGIT_W-1:0] s_d,
    output logic                   co,
    output logic                   bad
);

    logic [BCD_DIGIT_W:0] w_t;

    assign w_t = {1'b0, a_d} + {1'b0, b_d} + {{BCD_DIGIT_W{1'b0}}, ci};
    assign co  = (w_t > (BCD_DIGIT_W+1)'(BCD_MAX));
    // Only the low nibble of the corrected value is kept; the overflow is the carry.
    assign s_d = co ? (w_t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_CORR))
                    : w_t[BCD_DIGIT_W-1:0];
    assign bad = (a_d > BCD_DIGIT_W'(BCD_MAX)) | (b_d > BCD_DIGIT_W'(BCD_MAX));

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit per clock, LSD first, start/done handshake.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                          cin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          cout,
    output logic                          invalid
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_work;
    logic             r_inv_work;
    logic [W-1:0]     r_sum;
    logic             r_cout;
    logic             r_inv;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [BCD_DIGIT_W-1:0] w_s_d;
    logic             w_co;
    logic             w_bad;
    logic [W-1:0]     w_work_next;

    // Operands shift right each step so the active digit is always at the bottom.
    bcd_digit_add u_digit (
        .a_d (r_a[BCD_DIGIT_W-1:0]),
        .b_d (r_b[BCD_DIGIT_W-1:0]),
        .ci  (r_carry),
        .s_d (w_s_d),
        .co  (w_co),
        .bad (w_bad)
    );

    generate
        if (DIGITS == 1) begin : g_work_single
            assign w_work_next = w_s_d;
        end else begin : g_work_multi
            assign w_work_next = {w_s_d, r_work[W-1:BCD_DIGIT_W]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ADD;
                end
            end
            ADD: begin
                w_step = 1'b1;
                if (r_idx == IDX_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_work     <= '0;
            r_inv_work <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_inv      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_a        <= a;
                r_b        <= b;
                r_carry    <= cin;
                r_idx      <= '0;
                r_work     <= '0;
                r_inv_work <= 1'b0;
            end else if (w_step) begin
                r_a        <= r_a >> BCD_DIGIT_W;
                r_b        <= r_b >> BCD_DIGIT_W;
                r_carry    <= w_co;
                r_idx      <= r_idx + 1'b1;
                r_work     <= w_work_next;
                r_inv_work <= r_inv_work | w_bad;
                if (w_last) begin
                    r_sum  <= w_work_next;
                    r_cout <= w_co;
                    r_inv  <= r_inv_work | w_bad;
                end
            end
        end
    end

    assign busy    = (r_state == ADD);
    assign done    = r_done;
    assign sum     = r_sum;
    assign cout    = r_cout;
    assign invalid = r_inv;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized self-checking bench for bcd_serial_adder against a decimal reference model.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] prev_sum  = '0;
    logic         prev_cout = 1'b0;
    logic         prev_inv  = 1'b0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit all_valid(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] r = '0;
        int m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Valid operands use ordinary decimal arithmetic; invalid ones fall back to per-digit +6 rule.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] es, output logic ec, output logic ei);
        int lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        ei = !(all_valid(ma) && all_valid(mb));
        if (!ei) begin
            int t = bcd2int(ma) + bcd2int(mb) + int'(mc);
            ec = (t >= lim);
            es = int2bcd(t % lim);
        end else begin
            int c = int'(mc);
            es = '0;
            for (int i = 0; i < DIGITS; i++) begin
                int t = int'(ma[4*i +: 4]) + int'(mb[4*i +: 4]) + c;
                if (t > 9) begin
                    es[4*i +: 4] = 4'((t + 6) % 16);
                    c = 1;
                end else begin
                    es[4*i +: 4] = 4'(t);
                    c = 0;
                end
            end
            ec = c[0];
        end
    endtask

    // Called at a negedge; presents operands across one rising edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after the start edge; returns at the negedge where done is high.
    task automatic finish_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                             input bit noise);
        logic [W-1:0] es;
        logic         ec;
        logic         ei;
        int           cyc = 0;
        model(ia, ib, ic, es, ec, ei);
        while (!done && cyc < DIGITS + 4) begin
            cyc++;
            chk("busy_during_add", 32'(busy), 32'd1);
            chk("sum_hold", 32'(sum), 32'(prev_sum));
            chk("cout_hold", 32'(cout), 32'(prev_cout));
            if (noise) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_cycles", 32'(cyc), 32'(DIGITS));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("sum", 32'(sum), 32'(es));
        chk("cout", 32'(cout), 32'(ec));
        chk("invalid", 32'(invalid), 32'(ei));
        $display("op a=%h b=%h cin=%0d -> sum=%h cout=%0d invalid=%0d (exp %h %0d %0d)",
                 ia, ib, ic, sum, cout, invalid, es, ec, ei);
        prev_sum  = es;
        prev_cout = ec;
        prev_inv  = ei;
    endtask

    task automatic single_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        @(negedge clk);
        issue(ia, ib, ic);
        finish_op(ia, ib, ic, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_invalid", 32'(invalid), 32'd0);
        rst = 1'b0;

        single_op(16'h0123, 16'h0456, 1'b0);
        single_op(16'h9999, 16'h0001, 1'b0);
        single_op(16'h4999, 16'h5000, 1'b1);

        // Back-to-back: restart in the done cycle.
        @(negedge clk);
        issue(16'h0008, 16'h0005, 1'b0);
        finish_op(16'h0008, 16'h0005, 1'b0, 1'b0);
        issue(16'h0050, 16'h0050, 1'b0);
        finish_op(16'h0050, 16'h0050, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_done_clear", 32'(done), 32'd0);

        single_op(16'h000C, 16'h0003, 1'b0);
        single_op(16'h1234, 16'h4321, 1'b0);

        // Start pulses with other operands while busy must be ignored.
        @(negedge clk);
        issue(16'h2718, 16'h3141, 1'b1);
        finish_op(16'h2718, 16'h3141, 1'b1, 1'b1);
        @(negedge clk);
        chk("noise_single_done", 32'(done), 32'd0);
        chk("noise_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the second ADD cycle.
        @(negedge clk);
        issue(16'h5555, 16'h5555, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_invalid", 32'(invalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_sum  = '0;
        prev_cout = 1'b0;
        prev_inv  = 1'b0;
        for (int i = 0; i < DIGITS + 2; i++) begin
            chk("arst_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        single_op(16'h0999, 16'h0001, 1'b1);

        // Randomized operations, mostly valid, some with invalid digits, some back-to-back.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            for (int i = 0; i < DIGITS; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            rc = 1'($urandom);
            if (n > 0 && $urandom_range(0, 1) == 1 && done) begin
                issue(ra, rb, rc);
            end else begin
                @(negedge clk);
                issue(ra, rb, rc);
            end
            finish_op(ra, rb, rc, 1'b0);
        end
        @(negedge clk);
        chk("final_done_clear", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
Digit-serial, multi-digit packed-BCD adder with a start/done handshake. It generalises the single-digit combinational BCD adder to DIGITS decimal digits and adds carry-in, carry-out and invalid-digit detection. It processes one digit per clock, least-significant digit first, and sits between operand registers and the display/accumulator logic in the arithmetic datapath.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); operand and result width is 4*DIGITS bits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  4*DIGITS  packed BCD operand A; digit 0 is bits [3:0]
b  input  4*DIGITS  packed BCD operand B
cin  input  1  decimal carry-in, latched with the operands
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse when the result is valid
sum  output  4*DIGITS  packed BCD result; holds its value until the next completion
cout  output  1  decimal carry-out of the most significant digit
invalid  output  1  set if any operand digit was >9; valid with done

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, sum=0, cout=0, invalid=0, digit index=0, internal registers cleared.
- States: IDLE, ADD.
- IDLE: on a clock edge with start=1, latch a, b and cin. Set the carry register to cin and the index to 0. Clear the working invalid flag. Go to ADD with busy=1.
- ADD: each edge processes digit[index]:
  - t = a_d + b_d + carry (5-bit).
  - If t > 9: digit = (t + 6)[3:0] and carry = 1.
  - Otherwise: digit = t[3:0] and carry = 0.
  - invalid_work |= (a_d > 9) | (b_d > 9).
  - Shift the result digit into the working register, MSD side.
  - Increment index.
- Completion: the edge that processes digit DIGITS-1 also does the following:
  - sum <= working result including the final digit.
  - cout <= final carry.
  - invalid <= final invalid_work.
  - done <= 1, busy <= 0, next state IDLE.
- Latency: done is high in the cycle after the DIGITS-th edge following the start edge. busy is high for exactly DIGITS cycles.
- done is high for exactly one cycle and is otherwise 0.
- A start sampled while done=1 is accepted, so the block supports back-to-back operations with no gap cycle.
- start while busy=1: ignored, no queuing. Operand changes during ADD have no effect.
- sum, cout and invalid change only at completion or reset. They keep the previous result while busy.
- Invalid digits do not abort the operation. They are computed with the same correction rule, and the result is flagged by invalid.
- Reset mid-operation: abort immediately, no done pulse, all outputs return to their reset values.
- DIGITS=1: the block completes one edge after start.

Decomposition:
- Package bcd_pkg:
  - BCD_DIGIT_W = 4
  - BCD_MAX = 9
  - BCD_CORR = 6
  - state enumeration (IDLE, ADD)
- Sub-module bcd_digit_add (combinational):
  - inputs: a_d[3:0], b_d[3:0], ci
  - outputs: s_d[3:0], co, bad
  - Used once per cycle by the serial controller. It is reusable as the single-digit adder.

Test Plan:
1. DIGITS=4, a=16'h0123, b=16'h0456, cin=0, start pulse -> busy high 4 cycles; done pulse; sum=16'h0579, cout=0, invalid=0.
2. a=16'h9999, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. Then a=16'h4999, b=16'h5000, cin=1 -> sum=16'h0000, cout=1.
3. a=16'h0008, b=16'h0005 -> sum=16'h0013, cout=0. Then immediately restart in the done cycle with a=16'h0050, b=16'h0050 -> second done exactly 4 cycles later, sum=16'h0100.
4. Invalid digit: a=16'h000C, b=16'h0003 -> sum=16'h0015, cout=0, invalid=1. The next valid operation clears invalid to 0.
5. Start pulses while busy, with different operands -> ignored; result matches the first operands only, and there is a single done pulse.
6. Assert rst for 1 cycle at the 2nd ADD cycle -> busy=0, sum=0, cout=0, invalid=0 immediately (asynchronously); no done pulse. A subsequent start operates normally.
